fifo_pipe_slice: RTL and testbench
==================================

# fifo_pipe_slice

Two-entry registered ready/valid pipeline slice (skid buffer), the timing-isolating counterpart of the combinational bypass FIFO. The bypass FIFO forwards input to output in the same cycle; this block instead registers data, valid and ready. That cuts every combinational path between producer and consumer while keeping full throughput. It sits between scheduler pipeline stages and ahead of FIFO inputs wherever ready/valid paths fail timing.

## Interface
- DATA_WIDTH, 64, payload width in bits
- STALL_CNT_WIDTH, 32, width of the stall counter (used only with the configuration macro)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous assert, active-low reset; one clock; reset is asynchronous and active-low
- i__data_in_valid  input  1  producer valid
- i__data_in  input  DATA_WIDTH  producer payload
- o__data_in_ready  output  1  producer ready; driven straight from a flop
- o__data_out_valid  output  1  consumer valid; driven straight from a flop
- o__data_out  output  DATA_WIDTH  consumer payload; driven straight from a flop
- i__data_out_ready  input  1  consumer ready
- i__clear_all  input  1  synchronous flush of all entries
- o__occupancy  output  2  entries held (0..2)
- o__stall_count  output  STALL_CNT_WIDTH  consumer-stall cycle count (see Configuration)

## Operation
- Handshake definitions:
  - in_fire = i__data_in_valid & o__data_in_ready.
  - out_fire = o__data_out_valid & i__data_out_ready.
- Storage is a main register (drives o__data_out) and a skid register.
- State machine:
  - EMPTY (occ 0): in_fire → ONE, main←i__data_in.
  - ONE (occ 1):
    - in_fire & out_fire → ONE, main←i__data_in.
    - in_fire only → TWO, skid←i__data_in.
    - out_fire only → EMPTY.
    - neither → ONE, hold.
  - TWO (occ 2):
    - out_fire → ONE, main←skid.
    - otherwise hold; in_fire is impossible because ready is 0.
- o__data_out_valid = 1 in ONE and TWO.
- o__occupancy encodes the state directly.
- o__data_in_ready register loads (next_state != TWO). Ready is therefore 0 exactly in the cycles when the slice holds two entries.
- Order is strictly FIFO: no entry is duplicated, dropped (except by clear) or reordered.
- i__clear_all:
  - Next state is EMPTY and o__data_in_ready loads 1.
  - Clear has priority over same-cycle in_fire and out_fire; an entry accepted in a clear cycle is discarded.
  - Data registers keep stale contents, which are not observable because valid is 0.
- Producer rule: i__data_in must stay stable while valid and not ready. The slice never samples i__data_in outside in_fire.

## Timing
- Reset values (asynchronous, while reset_n = 0):
  - State EMPTY.
  - o__data_out_valid = 0, o__data_in_ready = 0, o__occupancy = 0, o__stall_count = 0.
  - o__data_out = 0.
- o__data_in_ready rises at the first clk edge after reset_n deasserts.
- Latency: data accepted at edge N appears on o__data_out with valid high after edge N.
- Throughput: one transfer per cycle sustained when the consumer is always ready. State stays ONE, and ready never drops.
- Back-pressure: a consumer stall while in ONE with in_fire moves the slice to TWO. Ready then drops after that edge, i.e. one cycle late, which the skid entry absorbs.
- No combinational path from any input to any output.
- Reset asserted mid-operation discards all entries immediately, without waiting for an edge.

## Configuration
- PIPE_SLICE_STATS_EN defined:
  - o__stall_count increments by 1 every cycle with o__data_out_valid & !i__data_out_ready.
  - It saturates at all-ones.
  - It is cleared by reset and by i__clear_all.
- PIPE_SLICE_STATS_EN undefined: o__stall_count is tied to 0 and no counter logic is built.

## Test plan
- Reset release:
  - During reset, all outputs are 0.
  - One edge after reset_n = 1, o__data_in_ready = 1 and o__data_out_valid = 0.
- Streaming: push 0x1..0x10 on consecutive cycles with consumer ready held 1. Required response:
  - Outputs 0x1..0x10 appear in order, one cycle delayed.
  - Ready never deasserts and occupancy stays ≤ 1.
- Skid fill: push 0xA then 0xB with consumer ready = 0. Required response:
  - Occupancy reaches 2 and ready = 0.
  - Output holds 0xA.
  - Raising consumer ready drains 0xA, then 0xB, in consecutive cycles, and ready returns to 1 after the first drain.
- Random throttle: 10k random valid/ready patterns. A scoreboard confirms exact ordered delivery with no loss or duplication, and confirms that payload is stable while valid & !ready.
- Clear: with occupancy 2, assert i__clear_all together with in_valid (0xC) and out_ready. Required response:
  - Next cycle, valid = 0, occupancy = 0, ready = 1.
  - 0xC is never output.
- Stats (PIPE_SLICE_STATS_EN): hold one entry with consumer ready = 0 for 5 cycles. o__stall_count = 5. A clear then returns it to 0.

Source files
------------

// File: rtl/fifo_pipe_slice.sv
// fifo_pipe_slice: two-entry registered ready/valid skid slice; define PIPE_SLICE_STATS_EN for the consumer-stall counter
module fifo_pipe_slice #(
    parameter int DATA_WIDTH      = 64,
    parameter int STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i__data_in_valid,
    input  logic [DATA_WIDTH-1:0]      i__data_in,
    output logic                       o__data_in_ready,
    output logic                       o__data_out_valid,
    output logic [DATA_WIDTH-1:0]      o__data_out,
    input  logic                       i__data_out_ready,
    input  logic                       i__clear_all,
    output logic [1:0]                 o__occupancy,
    output logic [STALL_CNT_WIDTH-1:0] o__stall_count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t state, next_state;
    logic [DATA_WIDTH-1:0] main_q, skid_q;
    logic valid_q, ready_q, in_fire, out_fire, load_main_in, load_main_skid, load_skid;
    assign in_fire  = i__data_in_valid & ready_q;
    assign out_fire = valid_q & i__data_out_ready;
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (i__clear_all) next_state = EMPTY;
        else case (state)
            EMPTY: if (in_fire) begin
                next_state   = ONE;
                load_main_in = 1'b1;
            end
            ONE: if (in_fire && out_fire) load_main_in = 1'b1;
                 else if (in_fire) begin
                     next_state = TWO;
                     load_skid  = 1'b1;
                 end
                 else if (out_fire) next_state = EMPTY;
            TWO: if (out_fire) begin
                next_state     = ONE;
                load_main_skid = 1'b1;
            end
            default: next_state = EMPTY;
        endcase
    end
    // valid and ready get their own flops so outputs never pass through decode logic
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= next_state;
            valid_q <= next_state != EMPTY;
            ready_q <= next_state != TWO;
            if (load_main_in) main_q <= i__data_in;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid) skid_q <= i__data_in;
        end
    end
    assign o__data_in_ready  = ready_q;
    assign o__data_out_valid = valid_q;
    assign o__data_out       = main_q;
    assign o__occupancy      = state;
`ifdef PIPE_SLICE_STATS_EN
    logic [STALL_CNT_WIDTH-1:0] stall_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_q <= '0;
        else if (i__clear_all) stall_q <= '0;
        else if (valid_q && !i__data_out_ready && !(&stall_q)) stall_q <= stall_q + STALL_CNT_WIDTH'(1);
    end
    assign o__stall_count = stall_q;
`else
    assign o__stall_count = '0;
`endif
endmodule

// File: tb/tb_fifo_pipe_slice.sv
// tb_fifo_pipe_slice: scoreboard bench for fifo_pipe_slice
module tb_fifo_pipe_slice;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, clear = 1'b0;
    logic [63:0] data_in = '0;
    logic        ready, out_valid;
    logic [63:0] data_out;
    logic [1:0]  occ;
    logic [31:0] stall_count;
    int n_checks = 0, n_fail = 0;
    logic [63:0] sb[$];
    logic mon_en = 1'b0, hold_prev = 1'b0, last_in_fire = 1'b0;
    logic [63:0] hold_data = '0;

    fifo_pipe_slice #(.DATA_WIDTH(64), .STALL_CNT_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .i__data_in_valid(in_valid), .i__data_in(data_in), .o__data_in_ready(ready),
        .o__data_out_valid(out_valid), .o__data_out(data_out), .i__data_out_ready(out_ready),
        .i__clear_all(clear), .o__occupancy(occ), .o__stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: queue length mirrors occupancy, pops must match output order
    always @(negedge clk) begin
        last_in_fire = in_valid && ready && !clear;
        if (mon_en) begin
            check("occ", 64'(occ), 64'(sb.size()));
            check("valid", 64'(out_valid), 64'(sb.size() != 0));
            check("ready", 64'(ready), 64'(sb.size() != 2));
            if (hold_prev) check("hold", data_out, hold_data);
            if (clear) begin
                sb.delete();
                hold_prev = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) check("underflow", 64'(sb.size()), 64'd1);
                    else check("order", data_out, sb.pop_front());
                end
                if (in_valid && ready) sb.push_back(data_in);
                hold_prev = out_valid && !out_ready;
                hold_data = data_out;
            end
        end
    end

    initial begin
        #12;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_occ", 64'(occ), 64'd0);
        check("rst_data", data_out, 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        check("rel_ready", 64'(ready), 64'd1);
        check("rel_valid", 64'(out_valid), 64'd0);
        mon_en = 1'b1;

        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            data_in = 64'(i);
            cyc();
            check("stream_out", data_out, 64'(i));
            check("stream_ready", 64'(ready), 64'd1);
        end
        in_valid = 1'b0;
        cyc();
        cyc();

        out_ready = 1'b0;
        in_valid = 1'b1;
        data_in = 64'hA;
        cyc();
        data_in = 64'hB;
        cyc();
        in_valid = 1'b0;
        check("skid_occ", 64'(occ), 64'd2);
        check("skid_ready", 64'(ready), 64'd0);
        check("skid_out", data_out, 64'hA);
        out_ready = 1'b1;
        cyc();
        check("drain1_out", data_out, 64'hB);
        check("drain1_ready", 64'(ready), 64'd1);
        cyc();
        check("drain2_valid", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        data_in = 64'h21;
        cyc();
        data_in = 64'h22;
        cyc();
        check("pre_clr_occ", 64'(occ), 64'd2);
        clear = 1'b1;
        data_in = 64'hC;
        out_ready = 1'b1;
        cyc();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_valid", 64'(out_valid), 64'd0);
        check("clr_occ", 64'(occ), 64'd0);
        check("clr_ready", 64'(ready), 64'd1);
        cyc();
        cyc();

        for (int i = 0; i < 10000; i++) begin
            if (!in_valid || last_in_fire) begin
                in_valid = 1'($urandom_range(0, 1));
                data_in = {$urandom(), $urandom()};
            end
            out_ready = $urandom_range(0, 3) != 0 ? ($urandom_range(0, 1) == 1) : 1'b0;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check("rand_drain", 64'(sb.size()), 64'd0);

`ifdef PIPE_SLICE_STATS_EN
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("stall_clr0", 64'(stall_count), 64'd0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        data_in = 64'h55;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        check("stall_5", 64'(stall_count), 64'd5);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("stall_clr", 64'(stall_count), 64'd0);
`else
        out_ready = 1'b0;
        in_valid = 1'b1;
        data_in = 64'h55;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        check("stall_off", 64'(stall_count), 64'd0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
`endif

        in_valid = 1'b1;
        data_in = 64'h77;
        cyc();
        in_valid = 1'b0;
        check("pre_arst_valid", 64'(out_valid), 64'd1);
        mon_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_occ", 64'(occ), 64'd0);
        check("arst_ready", 64'(ready), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
